// File: rtl/leb128_const_decoder_pkg.sv
// Shared types and constants for the LEB128 immediate decoder.
// Trap codes follow the CPU-wide trap encoding.
package leb128_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    DONE,
    ERROR
  } state_t;

  typedef logic [2:0] trap_t;

  localparam trap_t TRAP_NONE         = 3'd0;
  localparam trap_t TRAP_LEB_OVERLONG = 3'd5;
  localparam trap_t TRAP_LEB_OVERFLOW = 3'd6;

  localparam logic [3:0] LIMIT_32 = 4'd5;
  localparam logic [3:0] LIMIT_64 = 4'd10;

endpackage

// File: rtl/leb128_const_decoder_if.sv
// Fetch-side byte stream and operand result bundle for the LEB128 decoder.
interface leb128_const_decoder_if;
  import leb128_pkg::*;

  logic        start;
  logic        is_signed;
  logic        width64;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] result;
  logic        result_valid;
  logic        busy;
  trap_t       trap;

  modport master (
    output start, is_signed, width64, in_data, in_valid,
    input  in_ready, result, result_valid, busy, trap
  );

  modport slave (
    input  start, is_signed, width64, in_data, in_valid,
    output in_ready, result, result_valid, busy, trap
  );
endinterface

// File: rtl/leb128_const_decoder_final_check.sv
// Validates the unused high payload bits of a final byte that sits at the
// encoding length limit; shorter encodings always pass.
module leb128_final_check
  import leb128_pkg::*;
(
  input  logic [7:0] data_byte,
  input  logic       is_signed,
  input  logic       width64,
  input  logic [3:0] count,
  output logic       ok
);

  logic [3:0] limit;

  always_comb begin
    limit = width64 ? LIMIT_64 : LIMIT_32;
    ok    = 1'b1;
    if (count == limit) begin
      unique case ({width64, is_signed})
        2'b00: ok = (data_byte[6:4] == 3'b000);
        2'b01: ok = (data_byte[6:3] == 4'b0000) || (data_byte[6:3] == 4'b1111);
        2'b10: ok = (data_byte[6:1] == 6'b000000);
        2'b11: ok = (data_byte[6:0] == 7'h00) || (data_byte[6:0] == 7'h7F);
        default: ok = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/leb128_const_decoder.sv
// Streaming LEB128 immediate decoder: one byte per handshake, 32/64-bit,
// signed or unsigned, with sticky overlong/overflow traps.
module leb128_const_decoder
  import leb128_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 64
) (
  input logic                  clk,
  input logic                  reset,
  leb128_const_decoder_if.slave bus
);

  localparam int unsigned MAX_BYTES = (MAX_WIDTH + 6) / 7;

  state_t      state, state_next;
  trap_t       trap_q, trap_next;
  logic [63:0] acc, acc_next, fill, res_next, result_q;
  logic [6:0]  shift, shift_next, width;
  logic [3:0]  count, byte_num, limit;
  logic        sgn, w64, xfer, final_ok;

  assign bus.in_ready     = (state == DECODE);
  assign bus.busy         = (state == DECODE) || (state == DONE);
  assign bus.result_valid = (state == DONE);
  assign bus.result       = result_q;
  assign bus.trap         = trap_q;

  assign xfer     = (state == DECODE) && bus.in_valid;
  assign byte_num = count + 4'd1;
  assign limit    = w64 ? 4'(MAX_BYTES) : LIMIT_32;
  assign width    = w64 ? 7'd64 : 7'd32;

  leb128_final_check u_final_check (
    .data_byte (bus.in_data),
    .is_signed (sgn),
    .width64   (w64),
    .count     (byte_num),
    .ok        (final_ok)
  );

  // Sign fill covers only the bits above the payload actually received.
  always_comb begin
    shift_next = shift + 7'd7;
    acc_next   = acc | ({57'd0, bus.in_data[6:0]} << shift);
    fill       = '0;
    if (sgn && bus.in_data[6] && (shift_next < width))
      fill = ~((64'd1 << shift_next) - 64'd1);
    res_next = acc_next | fill;
    if (!w64)
      res_next[63:32] = '0;
  end

  always_comb begin
    state_next = state;
    trap_next  = trap_q;
    unique case (state)
      IDLE:   if (bus.start) state_next = DECODE;
      DECODE: begin
        if (xfer) begin
          if (!bus.in_data[7]) begin
            if (final_ok) begin
              state_next = DONE;
            end else begin
              state_next = ERROR;
              trap_next  = TRAP_LEB_OVERFLOW;
            end
          end else if (byte_num == limit) begin
            state_next = ERROR;
            trap_next  = TRAP_LEB_OVERLONG;
          end
        end
      end
      DONE:   state_next = IDLE;
      ERROR:  state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      trap_q   <= TRAP_NONE;
      acc      <= '0;
      shift    <= '0;
      count    <= '0;
      sgn      <= 1'b0;
      w64      <= 1'b0;
      result_q <= '0;
    end else begin
      state  <= state_next;
      trap_q <= trap_next;
      if (state == IDLE && bus.start) begin
        sgn   <= bus.is_signed;
        w64   <= bus.width64 && (MAX_WIDTH == 64);
        acc   <= '0;
        shift <= '0;
        count <= '0;
      end else if (xfer) begin
        acc   <= acc_next;
        shift <= shift_next;
        count <= byte_num;
        if (!bus.in_data[7] && final_ok)
          result_q <= res_next;
      end
    end
  end

endmodule

// File: tb/tb_leb128_const_decoder.sv
// Directed-vector bench for leb128_const_decoder with hand-computed results.
module tb_leb128_const_decoder;
  import leb128_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [7:0] byte_q[$];

  leb128_const_decoder_if dif ();

  leb128_const_decoder #(.MAX_WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // All stimulus tasks begin and end just after a falling edge.
  task automatic start_dec(input logic s, input logic w);
    dif.start     = 1'b1;
    dif.is_signed = s;
    dif.width64   = w;
    @(negedge clk);
    dif.start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    dif.in_data  = b;
    dif.in_valid = 1'b1;
    @(negedge clk);
    dif.in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic s, input logic w, input int stalls);
    start_dec(s, w);
    foreach (byte_q[i]) begin
      if (i > 0)
        for (int k = 0; k < stalls; k++) begin
          @(negedge clk);
          check({tag, " stall in_ready"}, 64'(dif.in_ready), 64'd1);
        end
      send_byte(byte_q[i]);
    end
  endtask

  task automatic expect_ok(input string tag, input logic [63:0] exp);
    check({tag, " result_valid"}, 64'(dif.result_valid), 64'd1);
    check({tag, " result"}, dif.result, exp);
    check({tag, " trap"}, 64'(dif.trap), 64'(TRAP_NONE));
    @(negedge clk);
    check({tag, " pulse end"}, 64'(dif.result_valid), 64'd0);
    check({tag, " busy end"}, 64'(dif.busy), 64'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    dif.start    = 1'b0;
    dif.is_signed = 1'b0;
    dif.width64  = 1'b0;
    dif.in_data  = '0;
    dif.in_valid = 1'b0;
    do_reset();

    check("rst in_ready", 64'(dif.in_ready), 64'd0);
    check("rst result", dif.result, 64'd0);
    check("rst result_valid", 64'(dif.result_valid), 64'd0);
    check("rst busy", 64'(dif.busy), 64'd0);
    check("rst trap", 64'(dif.trap), 64'(TRAP_NONE));

    // Signed 64-bit single byte, including handshake status before the byte.
    start_dec(1'b1, 1'b1);
    check("s64 42 busy", 64'(dif.busy), 64'd1);
    check("s64 42 in_ready", 64'(dif.in_ready), 64'd1);
    send_byte(8'h2A);
    expect_ok("s64 42", 64'd42);
    @(negedge clk);
    check("result hold", dif.result, 64'd42);

    byte_q = {8'h7F};
    run("s64 -1", 1'b1, 1'b1, 0);
    expect_ok("s64 -1", 64'hFFFF_FFFF_FFFF_FFFF);

    byte_q = {8'h7F};
    run("u32 7f", 1'b0, 1'b0, 0);
    expect_ok("u32 7f", 64'h0000_0000_0000_007F);

    byte_q = {8'hE5, 8'h8E, 8'h26};
    run("u64 624485", 1'b0, 1'b1, 2);
    expect_ok("u64 624485", 64'd624485);

    byte_q = {8'hC0, 8'hBB, 8'h78};
    run("s32 -123456", 1'b1, 1'b0, 0);
    expect_ok("s32 -123456", 64'h0000_0000_FFFE_1DC0);

    byte_q = {8'h80, 8'h00};
    run("u32 padded 0", 1'b0, 1'b0, 1);
    expect_ok("u32 padded 0", 64'd0);

    byte_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    run("u32 max", 1'b0, 1'b0, 0);
    expect_ok("u32 max", 64'h0000_0000_FFFF_FFFF);

    byte_q = {8'h80, 8'h80, 8'h80, 8'h80, 8'h78};
    run("s32 min", 1'b1, 1'b0, 0);
    expect_ok("s32 min", 64'h0000_0000_8000_0000);

    byte_q = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F};
    run("s64 min", 1'b1, 1'b1, 0);
    expect_ok("s64 min", 64'h8000_0000_0000_0000);

    byte_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    run("u64 max", 1'b0, 1'b1, 0);
    expect_ok("u64 max", 64'hFFFF_FFFF_FFFF_FFFF);

    // Overlong: continuation on byte 5 in 32-bit mode.
    start_dec(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("overlong in_ready", 64'(dif.in_ready), 64'd1);
      send_byte(8'h80);
      check("overlong no valid", 64'(dif.result_valid), 64'd0);
    end
    check("overlong trap", 64'(dif.trap), 64'(TRAP_LEB_OVERLONG));
    check("overlong ready low", 64'(dif.in_ready), 64'd0);
    check("overlong busy low", 64'(dif.busy), 64'd0);
    start_dec(1'b0, 1'b0);
    @(negedge clk);
    check("error start ignored busy", 64'(dif.busy), 64'd0);
    check("error start ignored ready", 64'(dif.in_ready), 64'd0);
    check("error trap sticky", 64'(dif.trap), 64'(TRAP_LEB_OVERLONG));
    check("error no valid", 64'(dif.result_valid), 64'd0);
    check("error result held", dif.result, 64'hFFFF_FFFF_FFFF_FFFF);
    do_reset();
    check("trap cleared", 64'(dif.trap), 64'(TRAP_NONE));

    byte_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
    run("u32 overflow", 1'b0, 1'b0, 0);
    check("u32 overflow trap", 64'(dif.trap), 64'(TRAP_LEB_OVERFLOW));
    check("u32 overflow no valid", 64'(dif.result_valid), 64'd0);
    do_reset();

    byte_q = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h40};
    run("s64 overflow", 1'b1, 1'b1, 0);
    check("s64 overflow trap", 64'(dif.trap), 64'(TRAP_LEB_OVERFLOW));
    do_reset();

    // Asynchronous reset in the middle of a cycle, away from any edge.
    byte_q = {8'h80, 8'h80};
    run("abort", 1'b0, 1'b1, 0);
    check("abort busy before", 64'(dif.busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async rst busy", 64'(dif.busy), 64'd0);
    check("async rst in_ready", 64'(dif.in_ready), 64'd0);
    check("async rst result", dif.result, 64'd0);
    check("async rst trap", 64'(dif.trap), 64'(TRAP_NONE));
    @(negedge clk);
    reset = 1'b0;
    byte_q = {8'h01};
    run("after abort", 1'b0, 1'b1, 0);
    expect_ok("after abort", 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/leb128_const_decoder.md
Name: leb128_const_decoder

Overview:
Streaming LEB128 immediate decoder for the CPU front end. It consumes the immediate bytes of i32.const and i64.const (signed), and of unsigned LEB128 indices, one byte per handshake from the instruction fetch path. It produces a 64-bit operand ready to push onto the operand stack. It generalises the fixed i64.const immediate path with selectable width (32/64) and signedness, wire-level back-pressure, and malformed-encoding traps.

Parameters:
MAX_WIDTH, 64, widest result in bits; the 64-bit mode is supported only when MAX_WIDTH=64 (32 or 64 allowed).
MAX_BYTES, derived localparam ceil(MAX_WIDTH/7), limit on encoded length (10 for MAX_WIDTH=64).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  begin a decode; honoured only in IDLE
is_signed  input  1  latched at start; 1 = SLEB128, 0 = ULEB128
width64  input  1  latched at start; 1 = 64-bit result, 0 = 32-bit result
in_data  input  8  encoded byte from fetch
in_valid  input  1  in_data valid
in_ready  output  1  decoder accepts in_data this cycle
result  output  64  decoded value
result_valid  output  1  one-cycle pulse; result valid
busy  output  1  decode in progress (DECODE or DONE)
trap  output  3  trap code; sticky until reset

Behaviour:
- Reset (asynchronous, active-high) values: in_ready=0, result=0, result_valid=0, busy=0, trap=TRAP_NONE, state=IDLE. Reset mid-decode abandons the decode and discards partial data.
- States:
  - IDLE: start=1 latches is_signed and width64, clears the accumulator, shift=0 and count=0, then moves to DECODE.
  - DECODE: in_ready=1 and busy=1. A transfer occurs when in_valid && in_ready. Each transfer ORs in_data[6:0]<<shift into the accumulator, then shift+=7 and count+=1. Cycles with in_valid=0 are stalls with no state change.
  - Final byte (in_data[7]=0): the final check passes -> DONE. The check fails -> ERROR with TRAP_LEB_OVERFLOW.
  - Continuation (in_data[7]=1) on byte number limit -> ERROR with TRAP_LEB_OVERLONG. limit = 5 in 32-bit mode, 10 in 64-bit mode.
  - DONE (one cycle): result_valid=1 and in_ready=0, then -> IDLE. Latency is one cycle from the final-byte transfer edge to result_valid.
  - ERROR: in_ready=0, busy=0, start ignored, trap held. Exit only by reset.
- Sign extension: applies when is_signed=1 and the final byte has in_data[6]=1. Bits from (shift_after_final) up to width-1 are filled with 1. If shift_after_final >= width, no fill is needed.
- Result width: 32-bit results are placed in result[31:0] with result[63:32]=0, for both signed and unsigned.
- Final-byte check, only on byte number limit:
  - 32-bit unsigned: bits[6:4]=0.
  - 32-bit signed: bits[6:3] all equal.
  - 64-bit unsigned: bits[6:1]=0.
  - 64-bit signed: bits[6:0] are 0x00 or 0x7F.
- Shorter encodings with redundant padding (e.g. 0x80 0x00) are legal.
- start outside IDLE is ignored. result holds its value until the next DONE.
- in_data is ignored whenever in_ready=0.

Decomposition:
- Package leb128_pkg holds:
  - state enum: IDLE, DECODE, DONE, ERROR.
  - trap codes: TRAP_NONE=3'd0, TRAP_LEB_OVERLONG=3'd5, TRAP_LEB_OVERFLOW=3'd6. These are shared with the CPU trap encoding.
  - byte-limit constants: 5 and 10.
- One combinational sub-module, leb128_final_check. Inputs: byte, is_signed, width64, count. Output: the ok flag. This keeps the boundary rules testable in isolation.

Test Plan:
- width64=1, signed, bytes 0x2A -> result=42, result_valid pulse one cycle after the transfer, trap=0.
- Single byte 0x7F: signed width64 -> 64'hFFFF_FFFF_FFFF_FFFF. Unsigned 32-bit -> 64'h0000_0000_0000_007F.
- Unsigned 64-bit, bytes 0xE5 0x8E 0x26, with in_valid low for 2 cycles between bytes -> result=624485. in_ready stays 1 during stalls.
- Signed 32-bit, bytes 0xC0 0xBB 0x78 -> result=64'h0000_0000_FFFE_1DC0 (-123456 in low word).
- Trap cases:
  - 32-bit, five bytes 0x80 0x80 0x80 0x80 0x80 -> trap=5, in_ready=0, result_valid never asserts, and a later start is ignored.
  - 32-bit unsigned, 0xFF 0xFF 0xFF 0xFF 0x1F -> trap=6.
  - 32-bit unsigned, 0xFF 0xFF 0xFF 0xFF 0x0F -> result=32'hFFFF_FFFF, no trap.
- Reset asserted asynchronously after two continuation bytes -> all outputs return to reset values immediately. A following decode of 0x01 yields result=1.
